// File: rtl/program_sequencer.sv
// program_sequencer: fetch/latch/execute controller between the program ROM
// and the processor. Owns the program counter, latches each instruction,
// issues a one-cycle execute strobe, and handles run, single-step, halt
// request, jump and HALT-opcode control.
module program_sequencer #(
  parameter int                         ADDR_W     = 2,
  parameter int                         DATA_W     = 8,
  parameter logic [DATA_W-1:0]          HALT_OP    = 8'hFF,
  parameter logic [DATA_W-ADDR_W-1:0]   JMP_PREFIX = 6'b111100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ir,
  output logic              exec_en,
  output logic              busy,
  output logic              halted,
  output logic              pc_wrap
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                halt_pend_q, halt_pend_d;
  logic                single_q, single_d;
  logic                pc_wrap_q, pc_wrap_d;
  logic                is_jump;

  // The jump test looks only at the latched instruction, never at ROM data.
  assign is_jump = (ir_q[DATA_W-1:ADDR_W] == JMP_PREFIX);

  // State and datapath registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      halt_pend_q <= 1'b0;
      single_q    <= 1'b0;
      pc_wrap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      halt_pend_q <= halt_pend_d;
      single_q    <= single_d;
      pc_wrap_q   <= pc_wrap_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    halt_pend_d = halt_pend_q;
    single_d    = single_q;
    pc_wrap_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // run wins over step when both are high
        if (run) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end
      end
      S_FETCH: begin
        // ROM registers address=pc at the end of this cycle
        halt_pend_d = halt_pend_q | halt_req;
        state_d     = S_LATCH;
      end
      S_LATCH: begin
        halt_pend_d = halt_pend_q | halt_req;
        ir_d        = instruction;
        // HALT word is latched but never executed; pc keeps pointing at it
        if (instruction == HALT_OP) state_d = S_HALTED;
        else                        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_jump) begin
          pc_d = ir_q[ADDR_W-1:0];
        end else begin
          pc_d      = pc_q + ADDR_W'(1);
          pc_wrap_d = &pc_q;
        end
        // A halt request raised in this very cycle still stops after this EXEC
        if (single_q || halt_pend_q || halt_req || !run) begin
          state_d     = S_IDLE;
          halt_pend_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registers, no input-to-output paths.
  always_comb begin
    exec_en = (state_q == S_EXEC);
    busy    = (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_EXEC);
    halted  = (state_q == S_HALTED);
    address = pc_q;
    ir      = ir_q;
    pc_wrap = pc_wrap_q;
  end

endmodule
